pipe_scroller: RTL and testbench



---
 rtl/pipe_scroller.sv | 145 ++++++++++++++
 tb/tb_pipe_scroller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroller.sv
// Scrolling pipe-column generator: turns the LFSR word into gapped pipe columns and scrolls them leftwards.
// Optional BCD score counter is built when SCORE_COUNTER_EN is defined.
module pipe_scroller #(
    parameter int unsigned COLS        = 16,
    parameter int unsigned ROWS        = 16,
    parameter int unsigned GAP         = 4,
    parameter int unsigned SPACING     = 5,
    parameter int unsigned TICK_CYCLES = 2500000,
    parameter int unsigned BIRD_COL    = 3
) (
    input  logic                 Clock,
    input  logic                 RST_n,
    input  logic                 start,
    input  logic                 freeze,
    input  logic [9:0]           lfsr_in,
    output logic [ROWS*COLS-1:0] pipes,
    output logic                 spawn,
    output logic                 score_pulse,
    output logic [7:0]           score
);

    localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned SW = (SPACING > 0) ? $clog2(SPACING + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] SPACE_LAST = SW'(SPACING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                   state;
    logic [TW-1:0]            tick;
    logic [SW-1:0]            space_cnt;
    logic [COLS-1:0][ROWS-1:0] field;
    logic [COLS-1:0]          is_pipe;
    logic [ROWS-1:0]          pipe_col;
    logic [ROWS-1:0]          new_col;
    int unsigned              gap_lo;
    logic                     scroll_now;
    logic                     insert_now;
    logic                     pass_now;
    logic                     restart;
    logic                     unused_lfsr;

    // Only the low nibble selects the gap; the upper bits are deliberately ignored.
    assign unused_lfsr = ^lfsr_in[9:4];

    assign pipes      = field;
    assign scroll_now = (state == RUN) && !freeze && (tick == TICK_LAST);
    assign insert_now = scroll_now && (space_cnt == SPACE_LAST);
    assign pass_now   = scroll_now && is_pipe[BIRD_COL];
    assign restart    = (state == HALT) && start && !freeze;

    always_comb begin
        gap_lo = 32'(lfsr_in[3:0]);
        if (gap_lo > ROWS - GAP) begin
            gap_lo = gap_lo - GAP;
        end
        pipe_col = '1;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (r >= gap_lo && r < gap_lo + GAP) begin
                pipe_col[r] = 1'b0;
            end
        end
        new_col = insert_now ? pipe_col : '0;
    end

    always_ff @(posedge Clock or negedge RST_n) begin
        if (!RST_n) begin
            state       <= IDLE;
            tick        <= '0;
            space_cnt   <= '0;
            field       <= '0;
            is_pipe     <= '0;
            spawn       <= 1'b0;
            score_pulse <= 1'b0;
        end else begin
            spawn       <= 1'b0;
            score_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // freeze takes priority over a coincident scroll edge
                    if (freeze) begin
                        state <= HALT;
                    end else if (scroll_now) begin
                        tick        <= '0;
                        field       <= {new_col, field[COLS-1:1]};
                        is_pipe     <= {insert_now, is_pipe[COLS-1:1]};
                        space_cnt   <= insert_now ? '0 : space_cnt + 1'b1;
                        spawn       <= insert_now;
                        score_pulse <= pass_now;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                HALT: begin
                    if (restart) begin
                        state     <= RUN;
                        tick      <= '0;
                        space_cnt <= '0;
                        field     <= '0;
                        is_pipe   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCORE_COUNTER_EN
    logic [3:0] score_hi;
    logic [3:0] score_lo;

    always_ff @(posedge Clock or negedge RST_n) begin
        if (!RST_n) begin
            score_hi <= '0;
            score_lo <= '0;
        end else if (restart) begin
            score_hi <= '0;
            score_lo <= '0;
        end else if (pass_now) begin
            if (score_lo == 4'd9) begin
                score_lo <= '0;
                score_hi <= (score_hi == 4'd9) ? 4'd0 : score_hi + 4'd1;
            end else begin
                score_lo <= score_lo + 4'd1;
            end
        end
    end

    assign score = {score_hi, score_lo};
`else
    assign score = 8'h00;
`endif

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomised self-checking bench for pipe_scroller against a column-array reference model.
module tb_pipe_scroller;

    localparam int COLS    = 16;
    localparam int ROWS    = 16;
    localparam int GAP     = 4;
    localparam int SPACING = 5;
    localparam int TICKS   = 4;
    localparam int BIRD    = 3;

    logic                 Clock = 1'b0;
    logic                 RST_n = 1'b1;
    logic                 start = 1'b0;
    logic                 freeze = 1'b0;
    logic [9:0]           lfsr_in = '0;
    logic [ROWS*COLS-1:0] pipes;
    logic                 spawn;
    logic                 score_pulse;
    logic [7:0]           score;

    pipe_scroller #(
        .COLS(COLS), .ROWS(ROWS), .GAP(GAP), .SPACING(SPACING),
        .TICK_CYCLES(TICKS), .BIRD_COL(BIRD)
    ) dut (
        .Clock(Clock), .RST_n(RST_n), .start(start), .freeze(freeze),
        .lfsr_in(lfsr_in), .pipes(pipes), .spawn(spawn),
        .score_pulse(score_pulse), .score(score)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;
    int passes_seen = 0;

    // Reference model: mode 0 idle, 1 running, 2 halted
    int              m_mode;
    int              m_tick;
    int              m_space;
    int              m_score;
    logic [ROWS-1:0] m_col [COLS];
    bit              m_flag [COLS];
    bit              m_spawn;
    bit              m_pass;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int n);
`ifdef SCORE_COUNTER_EN
        return {4'(n / 10), 4'(n % 10)};
`else
        return 8'h00 & 8'(n);
`endif
    endfunction

    function automatic logic [ROWS*COLS-1:0] m_pipes();
        logic [ROWS*COLS-1:0] p = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                p[c*ROWS + r] = m_col[c][r];
        return p;
    endfunction

    task automatic model_clear();
        m_tick  = 0;
        m_space = 0;
        m_score = 0;
        for (int c = 0; c < COLS; c++) begin
            m_col[c]  = '0;
            m_flag[c] = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_spawn = 0;
        m_pass  = 0;
        model_clear();
    endtask

    task automatic model_scroll();
        int v;
        int t;
        m_pass = m_flag[BIRD];
        if (m_pass) m_score = (m_score + 1) % 100;
        for (int c = 0; c < COLS - 1; c++) begin
            m_col[c]  = m_col[c+1];
            m_flag[c] = m_flag[c+1];
        end
        if (m_space == SPACING) begin
            v = int'(lfsr_in[3:0]);
            t = (v <= ROWS - GAP) ? v : v - GAP;
            m_col[COLS-1] = '1;
            for (int r = t; r < t + GAP; r++) m_col[COLS-1][r] = 1'b0;
            m_flag[COLS-1] = 1'b1;
            m_spawn = 1;
            m_space = 0;
        end else begin
            m_col[COLS-1]  = '0;
            m_flag[COLS-1] = 1'b0;
            m_space++;
        end
    endtask

    task automatic model_step();
        m_spawn = 0;
        m_pass  = 0;
        case (m_mode)
            0: if (start) m_mode = 1;
            1: begin
                if (freeze) m_mode = 2;
                else if (m_tick == TICKS - 1) begin
                    m_tick = 0;
                    model_scroll();
                end else m_tick++;
            end
            default: if (start && !freeze) begin
                m_mode = 1;
                model_clear();
            end
        endcase
    endtask

    task automatic compare_all();
        check("pipes", pipes, m_pipes());
        check("spawn", spawn, m_spawn);
        check("score_pulse", score_pulse, m_pass);
        check("score", score, bcd(m_score));
        if (score_pulse) passes_seen++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clock);
        #1;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [ROWS*COLS-1:0] frozen;
        bit done;

        // Reset and idle
        #2 RST_n = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        model_reset();
        check("rst_pipes", pipes, '0);
        check("rst_spawn", spawn, 1'b0);
        check("rst_pulse", score_pulse, 1'b0);
        check("rst_score", score, 8'h00);
        RST_n = 1'b1;
        repeat (50) cycle();
        check("idle_pipes", pipes, '0);

        // First pipe: gap rows 9..12
        lfsr_in = 10'h00D;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (23) cycle();
        check("first_spawn_early", spawn, 1'b0);
        cycle();
        check("first_spawn", spawn, 1'b1);
        check("first_col15", pipes[15*ROWS +: ROWS], 16'hE1FF);
        repeat (5) cycle();

        // Clamp and spacing, from a clean restart
        freeze = 1'b1;
        cycle();
        freeze = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        passes_seen = 0;
        lfsr_in = 10'h003;
        repeat (24) cycle();
        check("clamp_a_col15", pipes[15*ROWS +: ROWS], 16'hFF87);
        lfsr_in = 10'h00F;
        repeat (24) cycle();
        check("clamp_b_col15", pipes[15*ROWS +: ROWS], 16'h87FF);
        check("clamp_a_col9", pipes[9*ROWS +: ROWS], 16'hFF87);
        for (int c = 10; c < 15; c++) check("clamp_space", pipes[c*ROWS +: ROWS], 16'h0000);

        // Scoring through 100 passes
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            lfsr_in = 10'($urandom);
            cycle();
            if (score_pulse) begin
                if (passes_seen == 1) check("score_1", score, bcd(1));
                if (passes_seen == 10) check("score_10", score, bcd(10));
                if (passes_seen == 100) begin
                    check("score_wrap", score, bcd(0));
                    done = 1;
                end
            end
        end
        check("pass_budget", passes_seen, 100);

        // Freeze on the tick-terminal cycle
        for (int i = 0; i < 10 && !(m_mode == 1 && m_tick == TICKS - 1); i++) cycle();
        check("terminal_found", (m_mode == 1 && m_tick == TICKS - 1), 1'b1);
        frozen = m_pipes();
        freeze = 1'b1;
        cycle();
        for (int i = 0; i < 40; i++) begin
            start = 1'($urandom);
            lfsr_in = 10'($urandom);
            cycle();
            check("frozen_pipes", pipes, frozen);
            check("frozen_spawn", spawn, 1'b0);
        end
        start = 1'b0;
        freeze = 1'b0;
        repeat (3) cycle();
        check("halt_hold", pipes, frozen);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("restart_pipes", pipes, '0);
        check("restart_score", score, 8'h00);
        repeat (30) cycle();

        // Random start/freeze mix
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 15) == 0);
            freeze = ($urandom_range(0, 19) == 0);
            lfsr_in = 10'($urandom);
            cycle();
        end

        // Asynchronous reset while a spawn pulse is showing
        freeze = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 200 && !m_spawn; i++) begin
            lfsr_in = 10'($urandom);
            cycle();
        end
        check("spawn_found", spawn, 1'b1);
        #3 RST_n = 1'b0;
        #1;
        model_reset();
        check("async_pipes", pipes, '0);
        check("async_spawn", spawn, 1'b0);
        check("async_score", score, 8'h00);
        @(posedge Clock);
        #1;
        RST_n = 1'b1;
        repeat (30) cycle();
        check("post_reset_idle", pipes, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
